// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory controller.
// The master issues requests; the slave (dmem_ctrl) answers with one-cycle responses.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data memory for the MEM stage: byte/half/word access, fixed latency, error checks,
// zero-fill after reset. Define DMEM_STORE_LOG_EN to log every committed store.
module dmem_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    dmem_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT} state_t;

    state_t state, state_nx;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] clr_idx;
    logic [3:0]        lat_cnt;

    logic        we_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic              accept;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_word;
    logic [31:0]       merged;
    logic [31:0]       load_data;
    logic [31:0]       rdata_now;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    assign accept = bus.req_valid && (state == S_IDLE);
    // Gated by reset so a transaction abandoned in its final cycle neither responds nor writes.
    assign done   = (state == S_WAIT) && (lat_cnt == 4'd0) && !reset;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
            lat_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
            end
            if (accept) begin
                lat_cnt <= 4'(LATENCY - 1);
            end else if (state == S_WAIT && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_CLEAR: if (clr_idx == {ADDR_W{1'b1}}) state_nx = S_IDLE;
            S_IDLE:  if (bus.req_valid)             state_nx = S_WAIT;
            S_WAIT:  if (lat_cnt == 4'd0)           state_nx = S_IDLE;
            default: state_nx = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            sext_q  <= bus.req_sext;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    assign err = (size_q == 2'b11)
               || (size_q == 2'b01 && addr_q[0])
               || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
               || (|addr_q[31:ADDR_W+2]);

    assign word_idx = addr_q[ADDR_W+1:2];
    assign rd_word  = mem[word_idx];

    always_comb begin
        merged    = rd_word;
        load_data = rd_word;
        case (size_q)
            2'b00: begin
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
                load_data = {{24{sext_q & rd_word[{addr_q[1:0], 3'b111}]}},
                             rd_word[{addr_q[1:0], 3'b000} +: 8]};
            end
            2'b01: begin
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
                load_data = {{16{sext_q & rd_word[{addr_q[1], 4'b1111}]}},
                             rd_word[{addr_q[1], 4'b0000} +: 16]};
            end
            default: merged = wdata_q;
        endcase
    end

    assign rdata_now = (err || we_q) ? 32'd0 : load_data;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = word_idx;
        wr_data = merged;
        if (state == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_idx;
            wr_data = 32'd0;
        end else if (done && we_q && !err) begin
            wr_en = 1'b1;
        end
    end

    // NOTE: the array has no reset branch; the post-reset CLEAR walk zeroes it instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (done) begin
            rdata_q <= rdata_now;
            err_q   <= err;
        end
    end

`ifdef DMEM_STORE_LOG_EN
    logic [31:0] pc_q;

    always_ff @(posedge clk) begin
        if (accept) pc_q <= bus.req_pc;
        if (done && we_q && !err) begin
            $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00}, merged);
        end
    end
`endif

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.resp_valid = done;
    assign bus.resp_rdata = done ? rdata_now : rdata_q;
    assign bus.resp_err   = done ? err : err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl (ADDR_W=4, LATENCY=3): directed vectors queue their
// expected responses, a negedge monitor pops and compares on each resp_valid.
module tb_dmem_ctrl;
    localparam int ADDR_W  = 4;
    localparam int LATENCY = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    dmem_ctrl_if bus ();

    dmem_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every response against the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected resp_valid", 32'd1, 32'd0);
            end else begin
                exp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, " rdata"}, bus.resp_rdata, e.rdata);
                check({n, " err"}, {31'd0, bus.resp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic wait_clear(input string name);
        int cyc;
        cyc = 1;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " ready cycle"}, cyc, 32'((1 << ADDR_W) + 1));
        check({name, " busy idle"}, {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int w;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_sext  = sext;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_pc    = 32'h1000 + addr;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        bit got;
        bit ready_low;
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        name_q.push_back(name);
        issue(we, size, sext, addr, wdata);
        lat = 0;
        got = 1'b0;
        ready_low = 1'b1;
        while (!got && lat < 50) begin
            @(negedge clk);
            lat++;
            if (bus.req_ready !== 1'b0) ready_low = 1'b0;
            if (bus.resp_valid === 1'b1) got = 1'b1;
        end
        check({name, " latency"}, lat, LATENCY);
        check({name, " ready low"}, {31'd0, ready_low}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b00;
        bus.req_sext  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_pc    = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready",  {31'd0, bus.req_ready},  32'd0);
        check("reset valid",  {31'd0, bus.resp_valid}, 32'd0);
        check("reset rdata",  bus.resp_rdata,           32'd0);
        check("reset err",    {31'd0, bus.resp_err},   32'd0);
        check("reset busy",   {31'd0, bus.busy},       32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_clear("initial clear");

        do_req("load w0 after clear",  1'b0, 2'b10, 1'b0, 32'h0,  32'h0, 32'h0, 1'b0);
        do_req("load w15 after clear", 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);

        do_req("store word 0x8",  1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, 32'h0, 1'b0);
        do_req("store byte 0xB",  1'b1, 2'b00, 1'b0, 32'hB, 32'hFFFFFFAB, 32'h0, 1'b0);
        do_req("load word 0x8",   1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hAB345678, 1'b0);
        do_req("load byte 0x9 s", 1'b0, 2'b00, 1'b1, 32'h9, 32'h0, 32'h00000056, 1'b0);
        do_req("load byte 0xB s", 1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 32'hFFFFFFAB, 1'b0);
        do_req("load byte 0xB z", 1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'h000000AB, 1'b0);
        do_req("load half 0xA z", 1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'h0000AB34, 1'b0);
        do_req("load half 0x8 s", 1'b0, 2'b01, 1'b1, 32'h8, 32'h0, 32'h00005678, 1'b0);

        do_req("store word 8000", 1'b1, 2'b10, 1'b0, 32'h8, 32'h80000000, 32'h0, 1'b0);
        do_req("load half 0xA s", 1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'hFFFF8000, 1'b0);
        do_req("load half 0xA z2",1'b0, 2'b01, 1'b0, 32'hA, 32'h0, 32'h00008000, 1'b0);

        do_req("store half 0x10", 1'b1, 2'b01, 1'b0, 32'h10, 32'hDEAD1234, 32'h0, 1'b0);
        do_req("store half 0x12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, 32'h0, 1'b0);
        do_req("load word 0x10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF1234, 1'b0);
        do_req("load half 0x12 s",1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0);

        @(posedge clk); @(posedge clk); @(negedge clk);
        check("hold rdata", bus.resp_rdata, 32'hFFFFBEEF);
        check("hold err",   {31'd0, bus.resp_err}, 32'd0);
        @(posedge clk); #1;

        do_req("err word 0x6",    1'b0, 2'b10, 1'b0, 32'h6,  32'h0, 32'h0, 1'b1);
        do_req("err size 11",     1'b0, 2'b11, 1'b0, 32'h0,  32'h0, 32'h0, 1'b1);
        do_req("err half 0x5",    1'b0, 2'b01, 1'b1, 32'h5,  32'h0, 32'h0, 1'b1);
        do_req("err load 0x40",   1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);
        do_req("err store range", 1'b1, 2'b10, 1'b0, 32'h10000000, 32'hCAFEF00D, 32'h0, 1'b1);
        @(posedge clk); @(negedge clk);
        check("hold err flag", {31'd0, bus.resp_err}, 32'd1);
        @(posedge clk); #1;
        do_req("err store alias", 1'b1, 2'b10, 1'b0, 32'h48, 32'hDEADBEEF, 32'h0, 1'b1);
        do_req("err store align", 1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, 32'h0, 1'b1);
        do_req("unchanged w0",    1'b0, 2'b10, 1'b0, 32'h0,  32'h0, 32'h0, 1'b0);
        do_req("unchanged w8",    1'b0, 2'b10, 1'b0, 32'h8,  32'h0, 32'h80000000, 1'b0);
        do_req("unchanged w10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF1234, 1'b0);

        // Reset in the final WAIT cycle of a store: no response, no write, clear restarts.
        issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h55555555);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort no resp", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_clear("restart clear");
        do_req("load 0x4 after abort", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
        do_req("load 0x8 after clear", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
